vga_monitor: RTL
================

Name: vga_monitor

Overview:
- Receive-side counterpart of the vga timing generator: consumes hs/vs/RGB on the pixel clock and locks to the incoming frame timing.
- Reconstructs pixel coordinates, checks line and frame lengths, and accumulates a per-frame 16-bit pixel checksum.
- Used as in-system and simulation checker downstream of vga, on clk_vga, to verify graphics output without waveform inspection.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_SYNC, 96, hs pulse width (clocks)
- H_BP, 48, back porch (clocks)
- H_TOTAL, 800, clocks per line
- V_ACTIVE, 480, visible lines per frame
- V_SYNC, 2, vs pulse width (lines)
- V_BP, 33, back porch (lines)
- V_TOTAL, 525, lines per frame
- SYNC_POL, 0, asserted level of hs/vs

Ports:
- clk_vga  in  1  pixel clock
- rst_vga  in  1  asynchronous, active-low reset
- i_vga_hs  in  1  horizontal sync
- i_vga_vs  in  1  vertical sync
- i_vga_r/i_vga_g/i_vga_b  in  4 each  pixel colour
- i_clr_err  in  1  clears sticky error flags
- o_de  out  1  registered active-pixel strobe
- o_x  out  10  pixel column, valid with o_de
- o_y  out  10  pixel row, valid with o_de
- o_pix  out  12  {r,g,b}, valid with o_de
- o_locked  out  1  timing locked
- o_frame_done  out  1  one-cycle pulse, new o_frame_sum valid
- o_frame_sum  out  16  checksum of last good frame
- o_frame_cnt  out  16  good frames seen, wraps
- o_err_h  out  1  sticky line-length error
- o_err_v  out  1  sticky frame-length error

Behaviour:
- Reset (rst_vga=0, async): state SEARCH; all outputs and counters 0.
- Edge detect: hs/vs registered once. An assert edge is the first clock at which the input is sampled at SYNC_POL after being sampled deasserted.
- hcnt (10b): set to 0 on the hs assert-edge clock, else +1; saturates at 1023.
- Frame boundary: first hs assert edge at or after a vs assert edge (vs_pending flag). At the boundary vcnt=0; at other hs assert edges vcnt+1.
- Active region: hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and vcnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
  - x = hcnt-(H_SYNC+H_BP), y = vcnt-(V_SYNC+V_BP).
  - o_de/o_x/o_y/o_pix registered: 1-clock latency from the sampled input.
  - o_de asserts only in LOCKED.
- Line check: at every hs assert edge outside SEARCH, the previous line length (hcnt+1) must equal H_TOTAL. Also error as soon as hcnt reaches H_TOTAL with no edge (stuck sync).
- Frame check: at every frame boundary outside SEARCH, the line count (vcnt+1) must equal V_TOTAL.
- Error response: sets o_err_h / o_err_v (sticky until i_clr_err or reset; a set beats a clear in the same cycle). Next state is SEARCH, o_locked=0, sum discarded.
- Checksum: sum += zero-extended {r,g,b} mod 2^16 on each active pixel in ALIGN/LOCKED; cleared at each frame boundary.
- FSM:
  - SEARCH: wait for a frame boundary -> ALIGN (counters zeroed).
  - ALIGN: error -> SEARCH. Clean frame boundary -> LOCKED.
  - LOCKED: error -> SEARCH.
- Clean frame boundary (ALIGN->LOCKED, or LOCKED->LOCKED):
  - o_frame_sum <= final sum, including a pixel in that same cycle;
  - o_frame_done pulses;
  - o_frame_cnt+1;
  - o_locked=1 from the next clock.
- Error and boundary in the same clock: error wins, no frame_done.
- vs edge with no following hs edge before hcnt saturates: counts as an h error.

Test Plan:
- Nominal 640x480 generator, constant pixel 12'hFFF, 3 frames -> o_locked rises after 2nd frame boundary; each done pulse gives o_frame_sum=16'h5000; o_frame_cnt=1,2 at successive pulses.
- Pattern pix={x[3:0],y[3:0],4'h0}, locked -> first o_de with o_x=0,o_y=0 one clock after that pixel is driven; last o_de with o_x=639,o_y=479, o_pix=12'hFF0; exactly 307200 o_de per frame.
- Locked, inject one 799-clock line -> o_err_h=1, o_locked=0 at next clock, no frame_done that frame. Relock after 2 clean boundaries; o_err_h stays 1 until i_clr_err.
- Locked, one frame of 524 lines -> o_err_v=1 at the boundary, o_frame_done=0, o_locked=0.
- hs held deasserted while locked -> o_err_h=1 on the clock hcnt reaches 800.
- rst_vga low mid-line (between clock edges) -> all outputs 0 immediately. After release, no o_de until 2 frame boundaries are seen.

Source files
------------

// File: rtl/vga_monitor.sv
`default_nettype none
// ============================================================================
// vga_monitor : locks to incoming hs/vs timing, rebuilds pixel coordinates,
//               checks line/frame lengths and checksums each good frame.
// Revision    : 1.0
// ============================================================================
module vga_monitor #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   H_TOTAL  = 800,
    parameter int   V_ACTIVE = 480,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter int   V_TOTAL  = 525,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        clk_vga,
    input  logic        rst_vga,
    input  logic        i_vga_hs,
    input  logic        i_vga_vs,
    input  logic [3:0]  i_vga_r,
    input  logic [3:0]  i_vga_g,
    input  logic [3:0]  i_vga_b,
    input  logic        i_clr_err,
    output logic        o_de,
    output logic [9:0]  o_x,
    output logic [9:0]  o_y,
    output logic [11:0] o_pix,
    output logic        o_locked,
    output logic        o_frame_done,
    output logic [15:0] o_frame_sum,
    output logic [15:0] o_frame_cnt,
    output logic        o_err_h,
    output logic        o_err_v
);

    localparam logic [9:0] c_H_START  = 10'(H_SYNC + H_BP);
    localparam logic [9:0] c_H_END    = 10'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0] c_V_START  = 10'(V_SYNC + V_BP);
    localparam logic [9:0] c_V_END    = 10'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [9:0] c_H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] c_CNT_MAX  = 10'd1023;

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_ALIGN  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_hs_q, r_vs_q, r_vs_pending;
    logic [9:0]  r_hcnt, r_vcnt;
    logic [15:0] r_sum;
    logic        r_de, r_locked, r_frame_done, r_err_h, r_err_v;
    logic [9:0]  r_x, r_y;
    logic [11:0] r_pix;
    logic [15:0] r_frame_sum, r_frame_cnt;

    logic        w_hs_edge, w_vs_edge, w_pending, w_boundary, w_checking;
    logic [9:0]  w_hcnt, w_vcnt;
    logic        w_active, w_err_h, w_err_v, w_err_sat;
    logic [11:0] w_pix;
    logic [15:0] w_sum;

    // Counters describe the sample being taken this clock, so outputs lag input by one.
    assign w_hs_edge  = (i_vga_hs == SYNC_POL) && (r_hs_q != SYNC_POL);
    assign w_vs_edge  = (i_vga_vs == SYNC_POL) && (r_vs_q != SYNC_POL);
    assign w_pending  = r_vs_pending | w_vs_edge;
    assign w_boundary = w_hs_edge & w_pending;
    assign w_checking = (r_state != S_SEARCH);

    assign w_hcnt = w_hs_edge ? 10'd0 :
                    (r_hcnt == c_CNT_MAX) ? r_hcnt : r_hcnt + 10'd1;
    assign w_vcnt = w_boundary ? 10'd0 :
                    (w_hs_edge && (r_vcnt != c_CNT_MAX)) ? r_vcnt + 10'd1 : r_vcnt;

    assign w_active = (w_hcnt >= c_H_START) && (w_hcnt < c_H_END) &&
                      (w_vcnt >= c_V_START) && (w_vcnt < c_V_END);
    assign w_pix    = {i_vga_r, i_vga_g, i_vga_b};
    assign w_sum    = r_sum + ((w_active && w_checking) ? {4'd0, w_pix} : 16'd0);

    // A vs edge that never sees its hs edge before hcnt pins at max is a line fault.
    assign w_err_sat = w_pending && !w_hs_edge && (r_hcnt == c_CNT_MAX - 10'd1);
    assign w_err_h   = (w_checking && (w_hs_edge ? (r_hcnt != c_H_LAST)
                                                 : (r_hcnt == c_H_LAST))) || w_err_sat;
    assign w_err_v   = w_checking && w_boundary && (r_vcnt != c_V_LAST);

    always_ff @(posedge clk_vga or negedge rst_vga) begin
        if (!rst_vga) begin
            r_state      <= S_SEARCH;
            r_hs_q       <= 1'b0;
            r_vs_q       <= 1'b0;
            r_vs_pending <= 1'b0;
            r_hcnt       <= 10'd0;
            r_vcnt       <= 10'd0;
            r_sum        <= 16'd0;
            r_de         <= 1'b0;
            r_x          <= 10'd0;
            r_y          <= 10'd0;
            r_pix        <= 12'd0;
            r_locked     <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_sum  <= 16'd0;
            r_frame_cnt  <= 16'd0;
            r_err_h      <= 1'b0;
            r_err_v      <= 1'b0;
        end else begin
            r_hs_q       <= i_vga_hs;
            r_vs_q       <= i_vga_vs;
            r_hcnt       <= w_hcnt;
            r_vcnt       <= w_vcnt;
            r_vs_pending <= w_pending && !w_hs_edge && !w_err_sat;
            r_de         <= w_active && (r_state == S_LOCKED);
            if (w_active) begin
                r_x   <= w_hcnt - c_H_START;
                r_y   <= w_vcnt - c_V_START;
                r_pix <= w_pix;
            end
            r_frame_done <= 1'b0;
            r_err_h      <= w_err_h | (r_err_h & ~i_clr_err);
            r_err_v      <= w_err_v | (r_err_v & ~i_clr_err);

            if (w_err_h || w_err_v) begin
                r_state  <= S_SEARCH;
                r_locked <= 1'b0;
                r_sum    <= 16'd0;
            end else if (w_boundary) begin
                r_sum <= 16'd0;
                if (r_state == S_SEARCH) begin
                    r_state <= S_ALIGN;
                end else begin
                    r_state      <= S_LOCKED;
                    r_locked     <= 1'b1;
                    r_frame_done <= 1'b1;
                    r_frame_sum  <= w_sum;
                    r_frame_cnt  <= r_frame_cnt + 16'd1;
                end
            end else begin
                r_sum <= w_sum;
            end
        end
    end

    assign o_de         = r_de;
    assign o_x          = r_x;
    assign o_y          = r_y;
    assign o_pix        = r_pix;
    assign o_locked     = r_locked;
    assign o_frame_done = r_frame_done;
    assign o_frame_sum  = r_frame_sum;
    assign o_frame_cnt  = r_frame_cnt;
    assign o_err_h      = r_err_h;
    assign o_err_v      = r_err_v;

endmodule
`default_nettype wire
